// File: rtl/imem_serial_loader_if.sv
// Purpose : bundles the serial input and the instruction-memory write/status
//           outputs of the serial program loader into one port.
// Latency : none, wires only.
// Backpressure: none; the memory write port always accepts a strobe.
//
// Signals
//   Rx      serial input, idle high, asynchronous to the loader clock
//   WrEn    one-cycle write strobe to the instruction memory
//   WrAddr  word-aligned byte address of the write
//   WrData  instruction word, first received byte in bits [31:24]
//   CpuRst  processor reset request, high until the image is loaded
//   Done    image fully written, sticky until reset
//   Error   framing/length/checksum error, sticky until reset
//
// Modports
//   master  the loader: consumes Rx, drives the write port and status
//   slave   the environment: drives Rx, observes the write port and status
interface imem_serial_loader_if;
    logic        Rx;
    logic        WrEn;
    logic [31:0] WrAddr;
    logic [31:0] WrData;
    logic        CpuRst;
    logic        Done;
    logic        Error;

    modport master (
        input  Rx,
        output WrEn,
        output WrAddr,
        output WrData,
        output CpuRst,
        output Done,
        output Error
    );

    modport slave (
        output Rx,
        input  WrEn,
        input  WrAddr,
        input  WrData,
        input  CpuRst,
        input  Done,
        input  Error
    );
endinterface

// File: rtl/imem_serial_loader.sv
// Purpose : receives a program image over UART 8N1 and writes it word by word
//           into the instruction memory, holding the CPU in reset until done.
// Latency : WrEn pulses one cycle after the 4th byte of a word is accepted;
//           Done/CpuRst change one cycle after the state reaches DONE.
// Backpressure: none; the serial line cannot be stalled, and the memory
//           write port accepts every strobe.
//
// Ports
//   Clk   board clock, all logic on its rising edge
//   Rst   synchronous active-high reset, discards any partial frame or image
//   bus   imem_serial_loader_if.master (Rx in; WrEn/WrAddr/WrData/CpuRst/
//         Done/Error out)
//
// Image format: 16-bit word count N (MSB first), then 4*N data bytes, each
// word MSB first. N must not exceed 2**ADDR_WIDTH.
//
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to expect one trailing
// byte equal to the XOR of every preceding image byte (length included).
// ADDR_WIDTH is limited to 16 because the word count field is 16 bits wide.
module imem_serial_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                 Clk,
    input  logic                 Rst,
    imem_serial_loader_if.master bus
);

    localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_FULL = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_HALF = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [16:0]       MAX_WORDS = 17'(2 ** ADDR_WIDTH);

    // ------------------------------------------------------------------
    // Rx synchroniser (resets to the idle level so reset never looks like
    // a start bit)
    // ------------------------------------------------------------------
    logic rx_meta_q, rx_meta_d;
    logic rx_sync_q, rx_sync_d;

    always_comb begin
        rx_meta_d = bus.Rx;
        rx_sync_d = rx_meta_q;
    end

    // ------------------------------------------------------------------
    // Bit-level receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    rx_state_t         rx_state_q, rx_state_d;
    logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic [7:0]        rx_sr_q,    rx_sr_d;
    logic              byte_vld_q, byte_vld_d;
    logic              frame_err_q, frame_err_d;

    // Next-state logic. The start bit is re-checked at mid-bit so a short
    // low glitch drops back to idle silently; afterwards every sample point
    // is one full bit period later, i.e. in the middle of each bit.
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (baud_cnt_q == BAUD_HALF) rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (baud_cnt_q == BAUD_FULL && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            end
            RX_STOP: begin
                if (baud_cnt_q == BAUD_FULL) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Datapath/outputs of the receiver. The baud counter restarts on every
    // state change and at each data-bit sample point.
    always_comb begin
        baud_cnt_d  = baud_cnt_q + BAUD_W'(1);
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        byte_vld_d  = 1'b0;
        frame_err_d = 1'b0;

        if (rx_state_d != rx_state_q || rx_state_q == RX_IDLE) begin
            baud_cnt_d = '0;
        end

        case (rx_state_q)
            RX_IDLE: begin
                bit_cnt_d = 3'd0;
            end
            RX_DATA: begin
                if (baud_cnt_q == BAUD_FULL) begin
                    baud_cnt_d = '0;
                    rx_sr_d    = {rx_sync_q, rx_sr_q[7:1]};   // LSB arrives first
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                end
            end
            RX_STOP: begin
                if (baud_cnt_q == BAUD_FULL) begin
                    byte_vld_d  = rx_sync_q;
                    frame_err_d = !rx_sync_q;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Image-level frame decoder
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        F_LEN_HI,
        F_LEN_LO,
        F_DATA,
`ifdef IMEM_LOADER_CHECKSUM_EN
        F_CHK,
`endif
        F_DONE,
        F_ERR
    } frame_state_t;

    frame_state_t frame_state_q, frame_state_d;
    frame_state_t tail_state;
    logic [15:0]  len_q,      len_d;
    logic [15:0]  word_idx_q, word_idx_d;
    logic [1:0]   byte_cnt_q, byte_cnt_d;
    logic [23:0]  word_sr_q,  word_sr_d;
    logic         wr_en_q,    wr_en_d;
    logic [31:0]  wr_addr_q,  wr_addr_d;
    logic [31:0]  wr_data_q,  wr_data_d;
    logic         done_q,     done_d;
    logic         error_q,    error_d;
    logic         cpu_rst_q,  cpu_rst_d;
    logic [15:0]  n_words;
    logic         in_frame;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]   chk_q, chk_d;
`endif

    // Word count as it stands when the low length byte arrives.
    assign n_words  = {len_q[15:8], rx_sr_q};
    assign in_frame = (frame_state_q != F_DONE) && (frame_state_q != F_ERR);

    // State entered once all data words are in (or N==0).
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign tail_state = F_CHK;
`else
    assign tail_state = F_DONE;
`endif

    always_comb begin
        frame_state_d = frame_state_q;
        if (frame_err_q && in_frame) begin
            frame_state_d = F_ERR;
        end else if (byte_vld_q) begin
            case (frame_state_q)
                F_LEN_HI: frame_state_d = F_LEN_LO;
                F_LEN_LO: begin
                    if ({1'b0, n_words} > MAX_WORDS) frame_state_d = F_ERR;
                    else if (n_words == 16'd0)       frame_state_d = tail_state;
                    else                             frame_state_d = F_DATA;
                end
                F_DATA: begin
                    if (byte_cnt_q == 2'd3 && word_idx_q == len_q - 16'd1) begin
                        frame_state_d = tail_state;
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                F_CHK: frame_state_d = (rx_sr_q == chk_q) ? F_DONE : F_ERR;
`endif
                default: ;   // DONE ignores further bytes, ERR waits for Rst
            endcase
        end
    end

    // Outputs and datapath of the frame decoder. Bytes are collected in a
    // separate shift register so WrData only changes at a write strobe.
    always_comb begin
        len_d      = len_q;
        word_idx_d = word_idx_q;
        byte_cnt_d = byte_cnt_q;
        word_sr_d  = word_sr_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d      = chk_q;
`endif

        if (byte_vld_q) begin
            case (frame_state_q)
                F_LEN_HI: len_d[15:8] = rx_sr_q;
                F_LEN_LO: len_d       = n_words;
                F_DATA: begin
                    word_sr_d  = {word_sr_q[15:0], rx_sr_q};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_en_d    = 1'b1;
                        wr_data_d  = {word_sr_q, rx_sr_q};
                        wr_addr_d  = 32'({word_idx_q[ADDR_WIDTH-1:0], 2'b00});
                        word_idx_d = word_idx_q + 16'd1;
                    end
                end
                default: ;
            endcase
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (frame_state_q == F_LEN_HI || frame_state_q == F_LEN_LO ||
                frame_state_q == F_DATA) begin
                chk_d = chk_q ^ rx_sr_q;
            end
`endif
        end

        // Registered from the state so the release lands one cycle after
        // the final write strobe, never together with it.
        done_d    = (frame_state_q == F_DONE);
        error_d   = (frame_state_q == F_ERR);
        cpu_rst_d = (frame_state_q != F_DONE);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rx_meta_q     <= 1'b1;
            rx_sync_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            baud_cnt_q    <= '0;
            bit_cnt_q     <= 3'd0;
            rx_sr_q       <= 8'd0;
            byte_vld_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_state_q <= F_LEN_HI;
            len_q         <= 16'd0;
            word_idx_q    <= 16'd0;
            byte_cnt_q    <= 2'd0;
            word_sr_q     <= 24'd0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 32'd0;
            wr_data_q     <= 32'd0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            cpu_rst_q     <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q         <= 8'd0;
`endif
        end else begin
            rx_meta_q     <= rx_meta_d;
            rx_sync_q     <= rx_sync_d;
            rx_state_q    <= rx_state_d;
            baud_cnt_q    <= baud_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            rx_sr_q       <= rx_sr_d;
            byte_vld_q    <= byte_vld_d;
            frame_err_q   <= frame_err_d;
            frame_state_q <= frame_state_d;
            len_q         <= len_d;
            word_idx_q    <= word_idx_d;
            byte_cnt_q    <= byte_cnt_d;
            word_sr_q     <= word_sr_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            done_q        <= done_d;
            error_q       <= error_d;
            cpu_rst_q     <= cpu_rst_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q         <= chk_d;
`endif
        end
    end

    assign bus.WrEn   = wr_en_q;
    assign bus.WrAddr = wr_addr_q;
    assign bus.WrData = wr_data_q;
    assign bus.CpuRst = cpu_rst_q;
    assign bus.Done   = done_q;
    assign bus.Error  = error_q;

endmodule

// File: tb/tb_imem_serial_loader.sv
// Purpose : randomized and directed checks of imem_serial_loader against an
//           image-level reference model; a monitor compares every write strobe
//           with the queue of expected writes.
// Build   : define IMEM_LOADER_CHECKSUM_EN to exercise the checksum variant.
module tb_imem_serial_loader;

    localparam int CPB = 4;
    localparam int AW  = 8;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam int CHK_BYTES = 1;
`else
    localparam int CHK_BYTES = 0;
`endif

    typedef logic [7:0] bq_t[$];
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic Clk = 1'b0;
    logic Rst = 1'b1;
    imem_serial_loader_if bus();

    imem_serial_loader #(
        .CLKS_PER_BIT (CPB),
        .ADDR_WIDTH   (AW)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];
    bq_t  img;
    bq_t  spec_img;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected-write queue.
    initial begin
        wr_t w;
        forever begin
            @(negedge Clk);
            if (bus.WrEn === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                             bus.WrAddr, bus.WrData);
                end else begin
                    w = exp_q.pop_front();
                    check("wr_addr", bus.WrAddr, w.addr);
                    check("wr_data", bus.WrData, w.data);
                    check("done_low_during_write", 32'(bus.Done), 32'd0);
                    check("cpurst_high_during_write", 32'(bus.CpuRst), 32'd1);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        bus.Rx = 1'b1;
        Rst    = 1'b1;
        repeat (3) @(negedge Clk);
        Rst    = 1'b0;
        exp_q.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        bus.Rx = 1'b0;
        repeat (CPB) @(negedge Clk);
        for (int i = 0; i < 8; i++) begin
            bus.Rx = b[i];
            repeat (CPB) @(negedge Clk);
        end
        bus.Rx = !bad_stop;
        repeat (CPB) @(negedge Clk);
        bus.Rx = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    // Append the XOR of all image bytes when the checksum build is active.
    task automatic add_chk();
`ifdef IMEM_LOADER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        foreach (img[i]) x = x ^ img[i];
        img.push_back(x);
`endif
    endtask

    // Reference model over the whole byte stream in img. bad_idx marks the
    // byte whose stop bit is corrupted (-1 for none). Pushes expected writes
    // and returns the expected final Done/Error.
    task automatic model(input int bad_idx, output bit d, output bit e);
        int n, need, lim, words;
        logic [7:0] x;
        d = 1'b0;
        e = 1'b0;
        if (bad_idx == 0 || (bad_idx == 1 && img.size() >= 2)) begin
            e = 1'b1;
            return;
        end
        if (img.size() < 2) return;
        n = int'(img[0]) * 256 + int'(img[1]);
        if (n > 2 ** AW) begin
            e = 1'b1;
            return;
        end
        need = 2 + 4 * n + CHK_BYTES;
        lim  = img.size();
        if (bad_idx >= 0 && bad_idx < need) begin
            lim = bad_idx;
            e   = 1'b1;
        end
        words = (lim - 2) / 4;
        if (words > n) words = n;
        for (int w = 0; w < words; w++) begin
            exp_q.push_back('{addr: 32'(4 * w),
                              data: {img[2+4*w], img[3+4*w], img[4+4*w], img[5+4*w]}});
        end
        if (e || img.size() < need) return;
        x = 8'h00;
        for (int i = 0; i < need - CHK_BYTES; i++) x = x ^ img[i];
        if (CHK_BYTES == 1 && img[need-1] != x) e = 1'b1;
        else                                    d = 1'b1;
    endtask

    task automatic run_image(input string tag, input int bad_idx);
        bit d, e;
        model(bad_idx, d, e);
        foreach (img[i]) send_byte(img[i], i == bad_idx);
        repeat (12) @(negedge Clk);
        check({tag, "_done"},   32'(bus.Done),   32'(d));
        check({tag, "_error"},  32'(bus.Error),  32'(e));
        check({tag, "_cpurst"}, 32'(bus.CpuRst), 32'(!d));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, bad, need;
        bus.Rx   = 1'b1;
        spec_img = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h01, 8'h00, 8'h04};

        // Reset state
        do_reset();
        @(negedge Clk);
        check("rst_cpurst", 32'(bus.CpuRst), 32'd1);
        check("rst_done",   32'(bus.Done),   32'd0);
        check("rst_error",  32'(bus.Error),  32'd0);
        check("rst_wren",   32'(bus.WrEn),   32'd0);
        check("rst_wraddr", bus.WrAddr,      32'd0);
        check("rst_wrdata", bus.WrData,      32'd0);

        // Reference two-word image
        img = spec_img;
        add_chk();
        run_image("load", -1);

        // One-cycle glitch in idle, then a normal image
        do_reset();
        bus.Rx = 1'b0;
        @(negedge Clk);
        bus.Rx = 1'b1;
        repeat (30) @(negedge Clk);
        check("glitch_error", 32'(bus.Error), 32'd0);
        check("glitch_done",  32'(bus.Done),  32'd0);
        img = spec_img;
        add_chk();
        run_image("after_glitch", -1);

        // Bad stop bit on the 3rd byte
        do_reset();
        img = spec_img;
        add_chk();
        run_image("framing", 2);

        // Oversized length, then an empty image
        do_reset();
        img = '{8'h01, 8'h01};
        run_image("len257", -1);
        do_reset();
        img = '{8'h00, 8'h00};
        add_chk();
        run_image("len0", -1);

        // Largest allowed length: only the header is sent, no completion
        do_reset();
        img = '{8'h01, 8'h00};
        run_image("len256_partial", -1);

        // Reset mid-image, then the whole image again from address 0
        do_reset();
        for (int i = 0; i < 5; i++) send_byte(spec_img[i], 1'b0);
        do_reset();
        img = spec_img;
        add_chk();
        run_image("reload", -1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        img = spec_img;
        add_chk();
        img[img.size()-1] = img[img.size()-1] ^ 8'h01;
        run_image("bad_checksum", -1);
`endif

        // Randomized images with occasional stop-bit corruption and
        // trailing bytes after completion
        for (int it = 0; it < 8; it++) begin
            do_reset();
            n = $urandom_range(1, 6);
            img.delete();
            img.push_back(8'(n >> 8));
            img.push_back(8'(n));
            for (int k = 0; k < 4 * n; k++) img.push_back(8'($urandom));
            add_chk();
            need = img.size();
            bad  = -1;
            if ($urandom_range(0, 3) == 0) bad = $urandom_range(0, need - 1);
            if ($urandom_range(0, 1) == 1) img.push_back(8'($urandom));
            run_image("random", bad);
        end

        // Random oversized lengths
        for (int it = 0; it < 2; it++) begin
            do_reset();
            n = $urandom_range(2 ** AW + 1, 65535);
            img = '{8'(n >> 8), 8'(n)};
            run_image("random_oversize", -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
